// File: rtl/qvec_pkg.sv
// ---------------------------------------------------------------------------
// qvec_pkg
// Shared types and constants for the vector fixed-point add/subtract unit.
//   op_e      : per-beat operation select (OP_ADD = a+b, OP_SUB = a-b)
//   LANE_W    : default lane width in bits
//   lane_t    : one two's-complement lane at the default width
//   LANE_MAX  : most positive lane value, used as the positive clamp
//   LANE_MIN  : most negative lane value, used as the negative clamp
// ---------------------------------------------------------------------------
package qvec_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int LANE_W = 32;

    typedef logic [LANE_W-1:0] lane_t;

    localparam lane_t LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam lane_t LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

endpackage

// File: rtl/qvec_lane_addsub.sv
// ---------------------------------------------------------------------------
// qvec_lane_addsub
// One lane of the vector add/subtract unit. This block is purely combinational.
// It forms a+b or a-b in N+1 bits and flags two's-complement overflow.
// Configuration macro QVEC_ADDSUB_SAT_EN: when this macro is defined, an
// overflowing lane is clamped to the most positive or most negative value.
// When it is undefined, the result wraps modulo 2^N. In both builds the
// overflow flag is still raised.
// Ports:
//   a_i    in  N   operand A lane
//   b_i    in  N   operand B lane
//   op_i   in  1   OP_ADD / OP_SUB
//   c_o    out N   result lane
//   ovf_o  out 1   signed overflow for this lane
// ---------------------------------------------------------------------------
module qvec_lane_addsub
    import qvec_pkg::*;
#(
    parameter int N = LANE_W
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  op_e          op_i,
    output logic [N-1:0] c_o,
    output logic         ovf_o
);

`ifdef QVEC_ADDSUB_SAT_EN
    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};
`endif

    logic         carryIn;
    logic [N-1:0] bOperand;
    logic [N:0]   wideSum;

    // Subtraction is done as a + ~b + 1. Both operands are sign-extended to
    // N+1 bits, so wideSum holds the exact result. Overflow has occurred
    // when the extra top bit differs from the MSB of the N-bit result.
    // On overflow, wideSum[N] gives the true sign, which selects the clamp
    // direction.
    always_comb begin
        carryIn  = (op_i == OP_SUB);
        bOperand = carryIn ? ~b_i : b_i;
        wideSum  = {a_i[N-1], a_i} + {bOperand[N-1], bOperand} + {{N{1'b0}}, carryIn};
        ovf_o    = wideSum[N] ^ wideSum[N-1];
`ifdef QVEC_ADDSUB_SAT_EN
        if (ovf_o) begin
            c_o = wideSum[N] ? SAT_MIN : SAT_MAX;
        end else begin
            c_o = wideSum[N-1:0];
        end
`else
        c_o = wideSum[N-1:0];
`endif
    end

endmodule

// File: rtl/qvec_addsub_pipe.sv
// ---------------------------------------------------------------------------
// qvec_addsub_pipe
// Vector fixed-point add/subtract unit with RANK lanes of N-bit two's
// complement. It joins two operand streams and accepts one op per beat.
// The pipeline is LATENCY stages deep and supports full valid/ready
// backpressure. It also counts output beats that carry any overflow.
// Configuration macro QVEC_ADDSUB_SAT_EN: when defined, overflowing lanes
// clamp instead of wrapping. This is implemented in qvec_lane_addsub.
// Ports:
//   clk        in  1        clock
//   rst        in  1        synchronous, active-low reset
//   in_valid0  in  1        operand A valid
//   in_ready0  out 1        operand A ready
//   a          in  RANK*N   operand A lanes
//   in_valid1  in  1        operand B valid
//   in_ready1  out 1        operand B ready
//   b          in  RANK*N   operand B lanes
//   op         in  1        sampled with B: 0 = ADD, 1 = SUB
//   out_valid  out 1        result valid
//   out_ready  in  1        downstream ready
//   c          out RANK*N   result lanes
//   ovf        out RANK     per-lane overflow, aligned with c
//   ovf_count  out CNT_W    saturating count of delivered overflow beats
// ---------------------------------------------------------------------------
module qvec_addsub_pipe
    import qvec_pkg::*;
#(
    parameter int RANK    = 16,
    parameter int N       = 32,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid0,
    output logic                     in_ready0,
    input  logic [RANK-1:0][N-1:0]   a,
    input  logic                     in_valid1,
    output logic                     in_ready1,
    input  logic [RANK-1:0][N-1:0]   b,
    input  logic                     op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RANK-1:0][N-1:0]   c,
    output logic [RANK-1:0]          ovf,
    output logic [CNT_W-1:0]         ovf_count
);

    logic                   adv;
    logic                   accept;
    logic [RANK-1:0][N-1:0] laneSum;
    logic [RANK-1:0]        laneOvf;

    logic                   stageValid_q [LATENCY];
    logic [RANK-1:0][N-1:0] stageData_q  [LATENCY];
    logic [RANK-1:0]        stageOvf_q   [LATENCY];

    logic [CNT_W-1:0]       ovfCount_q;
    logic [CNT_W-1:0]       ovfCount_d;

    // The whole pipeline moves as one unit. It advances whenever the last
    // stage is empty or is being drained. A beat enters only when both
    // streams are presenting data. Each ready is gated by the other
    // stream's valid, so neither side is consumed alone.
    assign adv       = ~out_valid | out_ready;
    assign accept    = in_valid0 & in_valid1 & adv & rst;
    assign in_ready0 = adv & in_valid1 & rst;
    assign in_ready1 = adv & in_valid0 & rst;

    for (genvar g = 0; g < RANK; g++) begin : g_lane
        qvec_lane_addsub #(
            .N (N)
        ) u_lane (
            .a_i   (a[g]),
            .b_i   (b[g]),
            .op_i  (op_e'(op)),
            .c_o   (laneSum[g]),
            .ovf_o (laneOvf[g])
        );
    end

    // Stage 0 captures the arithmetic result. The later stages are a pure
    // delay line. Data is loaded even for bubbles because only the valid
    // bit carries meaning. When adv is low, every stage holds its value,
    // which keeps c/ovf stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                stageValid_q[k] <= 1'b0;
                stageData_q[k]  <= '0;
                stageOvf_q[k]   <= '0;
            end
            ovfCount_q <= '0;
        end else begin
            ovfCount_q <= ovfCount_d;
            if (adv) begin
                stageValid_q[0] <= accept;
                stageData_q[0]  <= laneSum;
                stageOvf_q[0]   <= laneOvf;
                for (int k = 1; k < LATENCY; k++) begin
                    stageValid_q[k] <= stageValid_q[k-1];
                    stageData_q[k]  <= stageData_q[k-1];
                    stageOvf_q[k]   <= stageOvf_q[k-1];
                end
            end
        end
    end

    // A beat is counted only when it is actually handed downstream. The
    // counter saturates at all-ones so that a long run cannot make it
    // appear small again.
    always_comb begin
        ovfCount_d = ovfCount_q;
        if (out_valid && out_ready && (|ovf) && (ovfCount_q != {CNT_W{1'b1}})) begin
            ovfCount_d = ovfCount_q + 1'b1;
        end
    end

    assign out_valid = stageValid_q[LATENCY-1];
    assign c         = stageData_q[LATENCY-1];
    assign ovf       = stageOvf_q[LATENCY-1];
    assign ovf_count = ovfCount_q;

endmodule

// File: tb/tb_qvec_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_qvec_addsub_pipe
// Directed testbench for qvec_addsub_pipe with RANK=4, N=32, LATENCY=2.
// The expected results follow QVEC_ADDSUB_SAT_EN in the same way as the
// design build does.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// one further unit later, so they are never sampled on an active edge.
// ---------------------------------------------------------------------------
module tb_qvec_addsub_pipe;

    localparam int RANK    = 4;
    localparam int N       = 32;
    localparam int LATENCY = 2;
    localparam int CNT_W   = 16;

`ifdef QVEC_ADDSUB_SAT_EN
    localparam logic [31:0] EXP_POS_OVF = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_NEG_OVF = 32'h8000_0000;
`else
    localparam logic [31:0] EXP_POS_OVF = 32'h8000_0000;
    localparam logic [31:0] EXP_NEG_OVF = 32'h7FFF_FFFF;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid0;
    logic                   in_ready0;
    logic [RANK-1:0][N-1:0] a;
    logic                   in_valid1;
    logic                   in_ready1;
    logic [RANK-1:0][N-1:0] b;
    logic                   op;
    logic                   out_valid;
    logic                   out_ready;
    logic [RANK-1:0][N-1:0] c;
    logic [RANK-1:0]        ovf;
    logic [CNT_W-1:0]       ovf_count;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    qvec_addsub_pipe #(
        .RANK    (RANK),
        .N       (N),
        .LATENCY (LATENCY),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid0 (in_valid0),
        .in_ready0 (in_ready0),
        .a         (a),
        .in_valid1 (in_valid1),
        .in_ready1 (in_ready1),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .ovf       (ovf),
        .ovf_count (ovf_count)
    );

    // Hold reset low for three edges while both streams present data. The
    // design must refuse input and show a cleared output.
    task automatic test_reset;
        rst       = 1'b0;
        in_valid0 = 1'b1;
        in_valid1 = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            testsRun++;
            if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_ready: got %b%b, expected 00", in_ready0, in_ready1);
            end
            testsRun++;
            if (out_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid);
            end
            testsRun++;
            if (c !== '0) begin
                testsFailed++;
                $display("[TB] FAIL reset_c: got %h, expected 0", c);
            end
            testsRun++;
            if (ovf_count !== '0) begin
                testsFailed++;
                $display("[TB] FAIL reset_ovf_count: got %0d, expected 0", ovf_count);
            end
        end
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
    endtask

    // Send two single beats: one ADD and one SUB. Each beat has lanes that
    // cover a normal sum, a negative result and a positive/negative
    // overflow. The test also checks the exact latency and the ovf_count
    // step that follows each beat.
    task automatic test_add_sub;
        logic [RANK-1:0][N-1:0] expC;
        logic [RANK-1:0]        expOvf;
        for (int beat = 0; beat < 2; beat++) begin
            if (beat == 0) begin
                op   = 1'b0;
                a[0] = 32'd3;          b[0] = 32'd5;          expC[0] = 32'h0000_0008;
                a[1] = 32'd100;        b[1] = 32'd200;        expC[1] = 32'h0000_012C;
                a[2] = 32'h7FFF_FFFF;  b[2] = 32'd1;          expC[2] = EXP_POS_OVF;
                a[3] = 32'hFFFF_FFFF;  b[3] = 32'hFFFF_FFFF;  expC[3] = 32'hFFFF_FFFE;
                expOvf = 4'b0100;
            end else begin
                op   = 1'b1;
                a[0] = 32'd10;         b[0] = 32'd4;          expC[0] = 32'h0000_0006;
                a[1] = 32'd1;          b[1] = 32'd2;          expC[1] = 32'hFFFF_FFFF;
                a[2] = 32'h8000_0000;  b[2] = 32'h8000_0000;  expC[2] = 32'h0000_0000;
                a[3] = 32'h8000_0000;  b[3] = 32'd1;          expC[3] = EXP_NEG_OVF;
                expOvf = 4'b1000;
            end
            in_valid0 = 1'b1;
            in_valid1 = 1'b1;
            out_ready = 1'b1;
            #1;
            testsRun++;
            if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL addsub_ready beat %0d: got %b%b, expected 11", beat, in_ready0, in_ready1);
            end
            @(posedge clk); #1;
            in_valid0 = 1'b0;
            in_valid1 = 1'b0;
            testsRun++;
            if (out_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL addsub_early beat %0d: got out_valid %b, expected 0", beat, out_valid);
            end
            @(posedge clk); #1;
            testsRun++;
            if (out_valid !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL addsub_latency beat %0d: got out_valid %b, expected 1", beat, out_valid);
            end
            for (int j = 0; j < RANK; j++) begin
                testsRun++;
                if (c[j] !== expC[j]) begin
                    testsFailed++;
                    $display("[TB] FAIL addsub_c beat %0d lane %0d: got %h, expected %h", beat, j, c[j], expC[j]);
                end
            end
            testsRun++;
            if (ovf !== expOvf) begin
                testsFailed++;
                $display("[TB] FAIL addsub_ovf beat %0d: got %b, expected %b", beat, ovf, expOvf);
            end
            testsRun++;
            if (ovf_count !== 16'(beat)) begin
                testsFailed++;
                $display("[TB] FAIL addsub_count_before beat %0d: got %0d, expected %0d", beat, ovf_count, beat);
            end
            @(posedge clk); #1;
            testsRun++;
            if (ovf_count !== 16'(beat + 1)) begin
                testsFailed++;
                $display("[TB] FAIL addsub_count_after beat %0d: got %0d, expected %0d", beat, ovf_count, beat + 1);
            end
            testsRun++;
            if (out_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL addsub_dup beat %0d: got out_valid %b, expected 0", beat, out_valid);
            end
        end
    endtask

    // Stream six ADD beats back to back, with out_ready low for cycles 3-7.
    // Beat k uses lane j = 0x100*k + j plus 0x10. The results must arrive
    // in order with no beat lost, and c must hold steady during the stall.
    task automatic test_back_to_back;
        logic [RANK-1:0][N-1:0] heldC;
        logic [31:0]            expLane;
        logic                   wasStalled;
        logic                   sawReadyDrop;
        logic                   acc;
        int                     sent;
        int                     recv;
        sent         = 0;
        recv         = 0;
        wasStalled   = 1'b0;
        sawReadyDrop = 1'b0;
        heldC        = '0;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            in_valid0 = (sent < 6);
            in_valid1 = (sent < 6);
            op        = 1'b0;
            for (int j = 0; j < RANK; j++) begin
                a[j] = 32'(32'h100 * sent + j);
                b[j] = 32'h10;
            end
            out_ready = !(cyc >= 3 && cyc < 8);
            #1;
            if (in_valid0 && !in_ready0) sawReadyDrop = 1'b1;
            if (wasStalled) begin
                testsRun++;
                if (out_valid !== 1'b1 || c !== heldC) begin
                    testsFailed++;
                    $display("[TB] FAIL stall_hold cycle %0d: got %b/%h, expected 1/%h", cyc, out_valid, c, heldC);
                end
            end
            if (out_valid && out_ready) begin
                for (int j = 0; j < RANK; j++) begin
                    expLane = 32'(32'h100 * recv + j + 32'h10);
                    testsRun++;
                    if (c[j] !== expLane) begin
                        testsFailed++;
                        $display("[TB] FAIL stream_c beat %0d lane %0d: got %h, expected %h", recv, j, c[j], expLane);
                    end
                end
                testsRun++;
                if (ovf !== 4'b0000) begin
                    testsFailed++;
                    $display("[TB] FAIL stream_ovf beat %0d: got %b, expected 0000", recv, ovf);
                end
                recv++;
            end
            wasStalled = out_valid && !out_ready;
            heldC      = c;
            acc        = in_valid0 && in_ready0;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        out_ready = 1'b1;
        testsRun++;
        if (recv != 6) begin
            testsFailed++;
            $display("[TB] FAIL stream_count: got %0d beats, expected 6", recv);
        end
        testsRun++;
        if (sawReadyDrop !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL stream_ready_drop: got %b, expected 1", sawReadyDrop);
        end
        testsRun++;
        if (ovf_count !== 16'd2) begin
            testsFailed++;
            $display("[TB] FAIL stream_ovf_count: got %0d, expected 2", ovf_count);
        end
        @(posedge clk); #1;
    endtask

    // First, operand A waits alone. A must not be accepted during this time.
    // Next, B joins and one beat is accepted, followed by a second beat.
    // Reset is then applied while both beats are in flight. Neither beat
    // may emerge afterwards.
    task automatic test_join_and_reset;
        op        = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < RANK; j++) begin
            a[j] = 32'd7;
            b[j] = 32'd1;
        end
        in_valid0 = 1'b1;
        in_valid1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            testsRun++;
            if (in_ready0 !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL join_wait_ready cycle %0d: got %b, expected 0", i, in_ready0);
            end
            @(posedge clk); #1;
            testsRun++;
            if (out_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL join_no_accept cycle %0d: got out_valid %b, expected 0", i, out_valid);
            end
        end
        in_valid1 = 1'b1;
        #1;
        testsRun++;
        if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL join_ready: got %b%b, expected 11", in_ready0, in_ready1);
        end
        @(posedge clk); #1;
        for (int j = 0; j < RANK; j++) begin
            a[j] = 32'd20;
            b[j] = 32'd2;
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
        testsRun++;
        if (out_valid !== 1'b1 || c[0] !== 32'd8) begin
            testsFailed++;
            $display("[TB] FAIL join_first_beat: got %b/%h, expected 1/00000008", out_valid, c[0]);
        end
        rst = 1'b0;
        #1;
        testsRun++;
        if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rst_mid_ready: got %b%b, expected 00", in_ready0, in_ready1);
        end
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rst_mid_out_valid: got %b, expected 0", out_valid);
        end
        testsRun++;
        if (ovf_count !== '0) begin
            testsFailed++;
            $display("[TB] FAIL rst_mid_ovf_count: got %0d, expected 0", ovf_count);
        end
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            testsRun++;
            if (out_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL rst_mid_flushed cycle %0d: got out_valid %b, expected 0", i, out_valid);
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        out_ready = 1'b1;
        op        = 1'b0;
        a         = '0;
        b         = '0;
        @(posedge clk); #1;
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_join_and_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
